// File: rtl/mogu_collide.sv
// Enemy collision checker: one enemy per cycle is tested against Mario after each
// frame tick, with a per-enemy IDLE/ALIVE/SQUASH/DEAD life cycle, scoring and invulnerability.
module mogu_collide #(
  parameter int unsigned MW           = 16,
  parameter int unsigned MH           = 16,
  parameter int unsigned STOMP_MARGIN = 4,
  parameter int unsigned SQUASH_TICKS = 8,
  parameter int unsigned INV_TICKS    = 32,
  parameter int unsigned STOMP_POINTS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        frame_tick,
  input  logic        spawn,
  input  logic [3:0]  MOGU,
  input  logic [10:0] C1,
  input  logic [10:0] C2,
  input  logic [10:0] C3,
  input  logic [10:0] C4,
  input  logic [10:0] R1,
  input  logic [10:0] R2,
  input  logic [10:0] R3,
  input  logic [10:0] R4,
  input  logic [10:0] mario_x,
  input  logic [10:0] mario_y,
  input  logic        mario_falling,
  output logic [3:0]  MM,
  output logic [3:0]  squash,
  output logic        stomp,
  output logic        mario_hit,
  output logic [15:0] score,
  output logic        busy
);

  localparam int unsigned SQW = $clog2(SQUASH_TICKS + 1);
  localparam int unsigned IVW = $clog2(INV_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIVE,
    S_SQUASH,
    S_DEAD
  } state_t;

  state_t         r_state    [4];
  state_t         w_state_nx [4];
  logic [SQW-1:0] r_sq_cnt    [4];
  logic [SQW-1:0] w_sq_cnt_nx [4];
  logic [IVW-1:0] r_inv_cnt, w_inv_cnt_nx;
  logic [1:0]     r_idx, w_idx_nx;
  logic           r_busy, w_busy_nx;
  logic [15:0]    r_score, w_score_nx;
  logic           r_stomp, w_stomp_nx;
  logic           r_hit, w_hit_nx;
  logic [3:0]     r_mm, w_mm_nx;
  logic [3:0]     r_sq, w_sq_nx;

  logic [10:0] w_cx [4];
  logic [10:0] w_ry [4];
  logic [11:0] w_ex, w_ey, w_mx, w_my;
  logic        w_overlap, w_stomp_geo;
  logic [16:0] w_score_sum;

  assign w_cx[0] = C1;
  assign w_cx[1] = C2;
  assign w_cx[2] = C3;
  assign w_cx[3] = C4;
  assign w_ry[0] = R1;
  assign w_ry[1] = R2;
  assign w_ry[2] = R3;
  assign w_ry[3] = R4;

  // 12-bit geometry so that position + sprite size never wraps
  assign w_ex = {1'b0, w_cx[r_idx]};
  assign w_ey = {1'b0, w_ry[r_idx]};
  assign w_mx = {1'b0, mario_x};
  assign w_my = {1'b0, mario_y};

  assign w_overlap = (w_mx < w_ex + 12'(MW)) && (w_ex < w_mx + 12'(MW)) &&
                     (w_my < w_ey + 12'(MH)) && (w_ey < w_my + 12'(MH));
  assign w_stomp_geo = mario_falling && (w_my + 12'(MH) <= w_ey + 12'(STOMP_MARGIN));
  assign w_score_sum = {1'b0, r_score} + 17'(STOMP_POINTS);

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_state_nx[i]  = r_state[i];
      w_sq_cnt_nx[i] = r_sq_cnt[i];
    end
    w_inv_cnt_nx = r_inv_cnt;
    w_idx_nx     = r_idx;
    w_busy_nx    = r_busy;
    w_score_nx   = r_score;
    w_stomp_nx   = 1'b0;
    w_hit_nx     = 1'b0;

    if (spawn) begin
      for (int unsigned i = 0; i < 4; i++)
        w_state_nx[i] = MOGU[i] ? S_ALIVE : S_IDLE;
      w_busy_nx = 1'b0;
      w_idx_nx  = 2'd0;
    end else if (r_busy) begin
      if (r_state[r_idx] == S_ALIVE && w_overlap) begin
        if (w_stomp_geo) begin
          w_state_nx[r_idx]  = S_SQUASH;
          w_sq_cnt_nx[r_idx] = SQW'(SQUASH_TICKS);
          w_stomp_nx         = 1'b1;
          w_score_nx         = w_score_sum[16] ? '1 : w_score_sum[15:0];
        end else if (r_inv_cnt == '0) begin
          w_hit_nx     = 1'b1;
          w_inv_cnt_nx = IVW'(INV_TICKS);
        end
      end
      w_idx_nx  = r_idx + 2'd1;
      w_busy_nx = (r_idx != 2'd3);
    end else if (active && frame_tick) begin
      w_busy_nx = 1'b1;
      w_idx_nx  = 2'd0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_state[i] == S_SQUASH) begin
          if (r_sq_cnt[i] <= SQW'(1)) begin
            w_state_nx[i]  = S_DEAD;
            w_sq_cnt_nx[i] = '0;
          end else begin
            w_sq_cnt_nx[i] = r_sq_cnt[i] - SQW'(1);
          end
        end
      end
      if (r_inv_cnt != '0)
        w_inv_cnt_nx = r_inv_cnt - IVW'(1);
    end

    for (int unsigned i = 0; i < 4; i++) begin
      w_mm_nx[i] = (w_state_nx[i] == S_ALIVE);
      w_sq_nx[i] = (w_state_nx[i] == S_SQUASH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_state[i]  <= S_IDLE;
        r_sq_cnt[i] <= '0;
      end
      r_inv_cnt <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_score   <= '0;
      r_stomp   <= 1'b0;
      r_hit     <= 1'b0;
      r_mm      <= '0;
      r_sq      <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_state[i]  <= w_state_nx[i];
        r_sq_cnt[i] <= w_sq_cnt_nx[i];
      end
      r_inv_cnt <= w_inv_cnt_nx;
      r_idx     <= w_idx_nx;
      r_busy    <= w_busy_nx;
      r_score   <= w_score_nx;
      r_stomp   <= w_stomp_nx;
      r_hit     <= w_hit_nx;
      r_mm      <= w_mm_nx;
      r_sq      <= w_sq_nx;
    end
  end

  assign MM        = r_mm;
  assign squash    = r_sq;
  assign stomp     = r_stomp;
  assign mario_hit = r_hit;
  assign score     = r_score;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mogu_collide.sv
// Bench for mogu_collide: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mogu_collide;

  logic        clk = 1'b0;
  logic        rst_n, active, frame_tick, spawn, mario_falling;
  logic [3:0]  MOGU;
  logic [10:0] cx [4];
  logic [10:0] ry [4];
  logic [10:0] mario_x, mario_y;
  logic [3:0]  MM, squash;
  logic        stomp, mario_hit, busy;
  logic [15:0] score;

  always #5 clk = ~clk;

  mogu_collide #(
    .MW(16), .MH(16), .STOMP_MARGIN(4), .SQUASH_TICKS(8), .INV_TICKS(32), .STOMP_POINTS(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .active(active), .frame_tick(frame_tick), .spawn(spawn),
    .MOGU(MOGU),
    .C1(cx[0]), .C2(cx[1]), .C3(cx[2]), .C4(cx[3]),
    .R1(ry[0]), .R2(ry[1]), .R3(ry[2]), .R4(ry[3]),
    .mario_x(mario_x), .mario_y(mario_y), .mario_falling(mario_falling),
    .MM(MM), .squash(squash), .stomp(stomp), .mario_hit(mario_hit),
    .score(score), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: life-cycle names in plain ints, pending scan as a queue of enemy numbers
  localparam int IDLE = 0, ALIVE = 1, SQUASHED = 2, DEAD = 3;
  int m_st [4];
  int m_sqleft [4];
  int m_inv;
  int m_score;
  int m_stomp, m_hit;
  int pend [$];
  bit chk_en = 0;

  function automatic bit collides(int i);
    int mx, my, c, r;
    mx = mario_x; my = mario_y; c = cx[i]; r = ry[i];
    return (mx < c + 16) && (c < mx + 16) && (my < r + 16) && (r < my + 16);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_st[i]) begin m_st[i] = IDLE; m_sqleft[i] = 0; end
      m_inv = 0; m_score = 0; m_stomp = 0; m_hit = 0;
      pend.delete();
    end else if (spawn) begin
      foreach (m_st[i]) m_st[i] = MOGU[i] ? ALIVE : IDLE;
      m_stomp = 0; m_hit = 0;
      pend.delete();
    end else begin
      m_stomp = 0; m_hit = 0;
      if (pend.size() > 0) begin
        int i;
        i = pend.pop_front();
        if (m_st[i] == ALIVE && collides(i)) begin
          if (mario_falling && (int'(mario_y) + 16 <= int'(ry[i]) + 4)) begin
            m_st[i] = SQUASHED; m_sqleft[i] = 8; m_stomp = 1;
            m_score = (m_score + 100 > 65535) ? 65535 : m_score + 100;
          end else if (m_inv == 0) begin
            m_hit = 1; m_inv = 32;
          end
        end
      end else if (active && frame_tick) begin
        pend = '{0, 1, 2, 3};
        foreach (m_st[i])
          if (m_st[i] == SQUASHED) begin
            m_sqleft[i]--;
            if (m_sqleft[i] == 0) m_st[i] = DEAD;
          end
        if (m_inv > 0) m_inv--;
      end
    end
  end

  function automatic logic [26:0] model_out();
    logic [3:0] mm, sq;
    for (int i = 0; i < 4; i++) begin
      mm[i] = (m_st[i] == ALIVE);
      sq[i] = (m_st[i] == SQUASHED);
    end
    return {mm, sq, 1'(m_stomp), 1'(m_hit), 16'(m_score), 1'(pend.size() > 0)};
  endfunction

  always @(negedge clk)
    if (chk_en) check("cycle_outputs", {MM, squash, stomp, mario_hit, score, busy}, model_out());

  int hit_cnt = 0, stomp_cnt = 0;
  always @(posedge clk) begin
    if (mario_hit === 1'b1) hit_cnt++;
    if (stomp === 1'b1) stomp_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan();
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(6);
  endtask

  task automatic do_spawn(input logic [3:0] m);
    spawn = 1'b1; MOGU = m; cyc(1); spawn = 1'b0;
  endtask

  task automatic set_all(input int c, input int r);
    for (int i = 0; i < 4; i++) begin cx[i] = 11'(c); ry[i] = 11'(r); end
  endtask

  initial begin
    int h0, s0, guard;
    rst_n = 1'b0; active = 1'b0; frame_tick = 1'b0; spawn = 1'b0; MOGU = '0;
    mario_falling = 1'b0; mario_x = 11'd0; mario_y = 11'd0;
    set_all(600, 600);
    cyc(3);
    check("reset_outputs", {MM, squash, stomp, mario_hit, score, busy}, 27'd0);
    chk_en = 1; rst_n = 1'b1; active = 1'b1;

    // 1: idle ticks with no enemies
    repeat (3) scan();
    check("idle_score", score, 16'd0);
    check("idle_hits", 64'(hit_cnt + stomp_cnt), 64'd0);

    // 2: spawn two enemies
    do_spawn(4'b0011);
    check("spawn_mm", {MM, squash, busy}, {4'b0011, 4'b0000, 1'b0});

    // 3: stomp on enemy 1
    cx[0] = 11'd100; ry[0] = 11'd144;
    mario_x = 11'd100; mario_y = 11'd130; mario_falling = 1'b1;
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    check("stomp_t2", {stomp, mario_hit, MM[0], squash[0], score}, {1'b1, 1'b0, 1'b0, 1'b1, 16'd100});
    cyc(5);
    repeat (7) scan();
    check("squash_7ticks", squash[0], 1'b1);
    scan();
    check("squash_8ticks", {squash[0], MM[0], MM[1]}, 3'b001);

    // 4: side hit and invulnerability window
    do_spawn(4'b0001);
    mario_x = 11'd90; mario_y = 11'd144; mario_falling = 1'b0;
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    check("side_hit_t2", {mario_hit, stomp, MM[0]}, 3'b101);
    cyc(5);
    h0 = hit_cnt;
    repeat (31) scan();
    check("inv_no_hit", 64'(hit_cnt - h0), 64'd0);
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    check("tick33_hit", mario_hit, 1'b1);
    cyc(5);

    // 5: edge cases
    mario_x = 11'd116; mario_y = 11'd144;
    guard = 0;
    while (m_inv != 0 && guard < 40) begin scan(); guard++; end
    check("inv_drained", 64'(guard < 40), 64'd1);
    h0 = hit_cnt;
    scan();
    check("touch_edge_no_hit", 64'(hit_cnt - h0), 64'd0);
    mario_x = 11'd100; mario_y = 11'd133; mario_falling = 1'b1;
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    check("margin_plus1_is_hit", {stomp, mario_hit}, 2'b01);
    cyc(5);

    // 6: spawn aborts a running scan
    set_all(100, 144);
    mario_x = 11'd100; mario_y = 11'd130; mario_falling = 1'b1;
    do_spawn(4'b1111);
    s0 = stomp_cnt;
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    check("abort_first_stomp", stomp, 1'b1);
    spawn = 1'b1; MOGU = 4'b1111; cyc(1); spawn = 1'b0;
    check("abort_state", {busy, MM}, {1'b0, 4'b1111});
    cyc(5);
    check("abort_no_more", 64'(stomp_cnt - s0), 64'd1);

    // randomized traffic near the enemies so collisions are frequent
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      spawn      = ($urandom_range(0, 39) == 0);
      MOGU       = 4'($urandom);
      frame_tick = ($urandom_range(0, 2) == 0);
      active     = ($urandom_range(0, 7) != 0);
      if (n % 12 == 0) begin
        for (int i = 0; i < 4; i++) begin
          cx[i] = 11'($urandom_range(80, 140));
          ry[i] = 11'($urandom_range(80, 140));
        end
        mario_x = 11'($urandom_range(70, 150));
        mario_y = 11'($urandom_range(70, 150));
        mario_falling = 1'($urandom);
      end
      cyc(1);
    end
    rst_n = 1'b1; spawn = 1'b0; frame_tick = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
